// File: rtl/dmem_bridge_pkg.sv
// Shared encodings for the M-stage data-memory bridge: FSM states,
// bus constants and the byte-enable selection helper.
package dmem_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0]  BE_WORD      = 4'b1111;
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          TIMER_W      = 8;

  // Loads always fetch the whole word; stores use the datapath's lane pattern.
  function automatic logic [3:0] bus_be(input logic wr, input logic [3:0] amp);
    return wr ? amp : BE_WORD;
  endfunction

endpackage

// File: rtl/dmem_bridge_timer.sv
// Wait-state counter for the bridge: cleared outside BUSY, counts unacked
// BUSY cycles and flags the last permitted one.
module dmem_bridge_timer
  import dmem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// Memory-stage bridge: turns each load/store into one req/ack bus
// transaction, stalls the pipeline until it completes and reports timeouts.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [DATA_W-1:0] wdataM,
  input  logic              memwriteM,
  input  logic              memreadM,
  input  logic [3:0]        ampM,
  output logic [DATA_W-1:0] rdataM,
  output logic              stallM,
  output logic              bus_err,
  output logic              err_sticky,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  logic [1:0]        r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_rdata;
  logic              r_bus_err;
  logic              r_err_sticky;

  logic w_write;
  logic w_access;
  logic w_idle;
  logic w_busy;
  logic w_expired;
  logic w_tmr_clr;
  logic w_tmr_en;

  // A store with no lanes selected is a no-op; an effective store beats a load.
  assign w_write  = memwriteM & (ampM != 4'b0000);
  assign w_access = memreadM | w_write;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_busy   = (r_state == ST_BUSY);

  assign w_tmr_clr = ~w_busy;
  assign w_tmr_en  = w_busy & ~mem_ack & ~w_expired;

  dmem_bridge_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= 4'b0000;
      r_rdata      <= '0;
      r_bus_err    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_addr  <= addrM & ~ADDR_W'(2'b11);
            r_we    <= w_write;
            r_wdata <= wdataM;
            r_be    <= bus_be(w_write, ampM);
            r_req   <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        // An ack in the timer's last cycle still completes normally.
        ST_BUSY: begin
          if (mem_ack) begin
            if (!r_we) begin
              r_rdata <= mem_rdata;
            end
            r_req   <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_expired) begin
            r_req        <= 1'b0;
            r_rdata      <= DATA_W'(BUS_ERR_DATA);
            r_bus_err    <= 1'b1;
            r_err_sticky <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Released in DONE so the pipeline advances past the completed access.
  assign stallM     = (w_idle & w_access) | w_busy;
  assign rdataM     = r_rdata;
  assign bus_err    = r_bus_err;
  assign err_sticky = r_err_sticky;
  assign mem_req    = r_req;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_be     = r_be;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with TIMEOUT=4: loads, stores, timeout,
// no-op store, stray ack, back-to-back accesses and reset mid-transaction.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addrM;
  logic [31:0] wdataM;
  logic        memwriteM;
  logic        memreadM;
  logic [3:0]  ampM;
  logic [31:0] rdataM;
  logic        stallM;
  logic        bus_err;
  logic        err_sticky;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addrM      (addrM),
    .wdataM     (wdataM),
    .memwriteM  (memwriteM),
    .memreadM   (memreadM),
    .ampM       (ampM),
    .rdataM     (rdataM),
    .stallM     (stallM),
    .bus_err    (bus_err),
    .err_sticky (err_sticky),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    memreadM  = 1'b0;
    memwriteM = 1'b0;
    addrM     = '0;
    wdataM    = '0;
    ampM      = 4'b0000;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  // Entered 1ns after an edge with the bridge in IDLE; returns in the first
  // cycle with stallM low (DONE, or IDLE for a no-op), 2ns after its edge.
  // The bus acks in BUSY cycle number ack_at (0-based); negative never acks.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] amp,
                     input int ack_at, input logic [31:0] rdat,
                     output int stalls, output int reqs, output logic first_req,
                     output logic [31:0] c_addr, output logic [31:0] c_wdata,
                     output logic [3:0] c_be, output logic c_we);
    int  idx;
    bit  done;
    memreadM  = rd;
    memwriteM = wr;
    addrM     = addr;
    wdataM    = wdata;
    ampM      = amp;
    mem_rdata = rdat;
    stalls = 0; reqs = 0; idx = 0; done = 0; first_req = 1'b0;
    c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      mem_ack = (mem_req && idx == ack_at);
      #1;
      if (cyc == 0) first_req = mem_req;
      if (mem_req) begin
        if (idx == 0) begin
          c_addr = mem_addr; c_wdata = mem_wdata; c_be = mem_be; c_we = mem_we;
        end
        idx++;
        reqs++;
      end
      if (stallM) stalls++;
      else done = 1;
      if (!done) step();
    end
    if (!done) chk("txn_bound", 32'd0, 32'd1);
    mem_ack = 1'b0;
  endtask

  int          st, rq;
  logic        fr;
  logic [31:0] ca, cw;
  logic [3:0]  cb;
  logic        cwe;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_rdata", rdataM, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_stall", {31'b0, stallM}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_err", {30'b0, bus_err, err_sticky}, 32'd0);
    step();

    // lw, zero-wait bus
    txn(1'b1, 1'b0, 32'h1004, 32'h0, 4'b0000, 0, 32'h1234_5678, st, rq, fr, ca, cw, cb, cwe);
    chk("lw_stalls", st, 32'd2);
    chk("lw_reqs", rq, 32'd1);
    chk("lw_addr", ca, 32'h1004);
    chk("lw_be", {28'b0, cb}, 32'hF);
    chk("lw_we", {31'b0, cwe}, 32'd0);
    chk("lw_rdata", rdataM, 32'h1234_5678);
    chk("lw_req_done", {31'b0, mem_req}, 32'd0);
    step();
    clear_inputs();

    // sh, ack on the timer's last cycle
    txn(1'b0, 1'b1, 32'h2002, 32'hABCD_0000, 4'b1100, 3, 32'hFFFF_FFFF, st, rq, fr, ca, cw, cb, cwe);
    chk("sh_stalls", st, 32'd5);
    chk("sh_reqs", rq, 32'd4);
    chk("sh_addr", ca, 32'h2000);
    chk("sh_be", {28'b0, cb}, 32'hC);
    chk("sh_we", {31'b0, cwe}, 32'd1);
    chk("sh_wdata", cw, 32'hABCD_0000);
    chk("sh_rdata_hold", rdataM, 32'h1234_5678);
    chk("sh_no_err", {30'b0, bus_err, err_sticky}, 32'd0);
    step();
    clear_inputs();

    // lw, bus never acks
    txn(1'b1, 1'b0, 32'h4000, 32'h0, 4'b0000, -1, 32'h0, st, rq, fr, ca, cw, cb, cwe);
    chk("to_stalls", st, 32'd5);
    chk("to_reqs", rq, 32'd4);
    chk("to_rdata", rdataM, 32'hDEAD_BEEF);
    chk("to_buserr_done", {31'b0, bus_err}, 32'd1);
    chk("to_sticky_done", {31'b0, err_sticky}, 32'd1);
    step();
    clear_inputs();
    #1;
    chk("to_buserr_after", {31'b0, bus_err}, 32'd0);
    chk("to_sticky_after", {31'b0, err_sticky}, 32'd1);
    #(-1ns + 1ns);

    // store with no lanes
    txn(1'b0, 1'b1, 32'h5000, 32'h1111_1111, 4'b0000, 0, 32'h0, st, rq, fr, ca, cw, cb, cwe);
    chk("noop_stalls", st, 32'd0);
    chk("noop_reqs", rq, 32'd0);
    step();
    chk("noop_req_after", {31'b0, mem_req}, 32'd0);
    clear_inputs();

    // stray ack in IDLE
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    step();
    step();
    #1;
    chk("stray_req", {31'b0, mem_req}, 32'd0);
    chk("stray_stall", {31'b0, stallM}, 32'd0);
    chk("stray_rdata", rdataM, 32'hDEAD_BEEF);
    chk("stray_buserr", {31'b0, bus_err}, 32'd0);
    clear_inputs();
    step();

    // sw (with memreadM also set: write wins) then lw back-to-back
    txn(1'b1, 1'b1, 32'h3008, 32'h55AA_55AA, 4'b1111, 0, 32'h9999_9999, st, rq, fr, ca, cw, cb, cwe);
    chk("sw_stalls", st, 32'd2);
    chk("sw_we", {31'b0, cwe}, 32'd1);
    chk("sw_be", {28'b0, cb}, 32'hF);
    chk("sw_wdata", cw, 32'h55AA_55AA);
    chk("sw_rdata_hold", rdataM, 32'hDEAD_BEEF);
    chk("sw_req_done", {31'b0, mem_req}, 32'd0);
    step();
    txn(1'b1, 1'b0, 32'h300C, 32'h0, 4'b0000, 0, 32'hCAFE_F00D, st, rq, fr, ca, cw, cb, cwe);
    chk("b2b_gap_idle", {31'b0, fr}, 32'd0);
    chk("b2b_stalls", st, 32'd2);
    chk("b2b_addr", ca, 32'h300C);
    chk("b2b_rdata", rdataM, 32'hCAFE_F00D);
    step();
    clear_inputs();

    // reset in the second BUSY cycle
    memreadM = 1'b1;
    addrM    = 32'h6004;
    step();
    step();
    chk("rb_busy_req", {31'b0, mem_req}, 32'd1);
    reset    = 1'b1;
    memreadM = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("rb_req", {31'b0, mem_req}, 32'd0);
    chk("rb_stall", {31'b0, stallM}, 32'd0);
    chk("rb_rdata", rdataM, 32'h0);
    chk("rb_sticky", {31'b0, err_sticky}, 32'd0);
    chk("rb_addr", mem_addr, 32'h0);
    step();
    chk("rb_idle_req", {31'b0, mem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Memory-stage data-memory bridge, sitting directly downstream of the pipeline datapath's M-stage memory outputs (address, write data, write enable, access pattern).
- Converts each load/store into one transaction on a req/ack data bus that may insert wait states.
- Returns the full read word to the datapath and raises a pipeline stall until the access completes.
- Bus timeout is detected and reported.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32 for byte-enable logic)
- TIMEOUT, 255, max BUSY cycles without ack before bus error (1..255)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- addrM  in  ADDR_W  byte address (ALU result)
- wdataM  in  DATA_W  store data, already lane-aligned by datapath
- memwriteM  in  1  store request
- memreadM  in  1  load request (memtoreg)
- ampM  in  4  store byte-lane pattern
- rdataM  out  DATA_W  read word to datapath, unextracted
- stallM  out  1  freeze F/D/E/M pipeline registers
- bus_err  out  1  one-cycle pulse on timeout
- err_sticky  out  1  set on timeout, cleared only by reset
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  word-aligned bus address
- mem_wdata  out  DATA_W  bus write data
- mem_be  out  4  bus byte enables
- mem_rdata  in  DATA_W  bus read data
- mem_ack  in  1  bus completion, valid only while mem_req=1

Behaviour:
- Reset values: state=IDLE; mem_req, mem_we, bus_err, err_sticky, timer all 0; rdataM, mem_addr, mem_wdata, mem_be all 0.
- access = memreadM | (memwriteM & ampM!=0).
- If memwriteM=1 and ampM=0: no-op, no stall, no bus activity.
- If memreadM and memwriteM are both 1, the write wins.
- FSM states:
  - IDLE:
    - stallM = access (combinational).
    - If access, latch request registers and go to BUSY:
      - mem_addr = {addrM[ADDR_W-1:2], 2'b00}
      - mem_we = memwriteM
      - mem_wdata = wdataM
      - mem_be = ampM for a write, 4'b1111 for a read
    - mem_req <= 1; timer <= 0.
  - BUSY:
    - mem_req=1, stallM=1.
    - mem_ack=1: capture rdataM <= mem_rdata (reads only; rdataM holds on writes), mem_req <= 0, go to DONE.
    - Else, timer == TIMEOUT-1: mem_req <= 0, rdataM <= 32'hDEAD_BEEF, bus_err pulses in DONE, err_sticky <= 1, go to DONE.
    - Else timer++.
  - DONE:
    - stallM=0, so the pipeline advances at this edge.
    - Go to IDLE. The next M instruction is evaluated in IDLE the following cycle.
- Latency: a zero-wait bus gives 2 stall cycles (IDLE, BUSY), with rdataM valid in DONE. Each extra bus wait cycle adds one stall cycle.
- Request registers and M inputs are not re-sampled while BUSY. The datapath holds M inputs stable while stallM=1.
- mem_ack seen outside BUSY is ignored.
- Ack arriving in the same cycle the timer expires: the ack wins and no error is raised.
- Reset during BUSY: the transaction is abandoned; mem_req drops at the next edge and all registers take their reset values.
- A consecutive access always passes through DONE→IDLE, so there are no back-to-back bus requests.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - BE_WORD=4'b1111
  - BUS_ERR_DATA=32'hDEAD_BEEF
- One sub-module, bridge_timer: 8-bit counter with clear/enable and an expired output at TIMEOUT-1.

Test Plan:
- lw at addrM=0x1004, ack in first BUSY cycle with mem_rdata=0x12345678:
  - mem_addr=0x1004, mem_be=1111, mem_we=0
  - stallM high for 2 cycles, rdataM=0x12345678 in DONE.
- sh at addrM=0x2002, ampM=1100, wdataM=0xABCD0000, ack after 3 wait cycles:
  - mem_addr=0x2000, mem_be=1100, mem_we=1
  - stallM high for 5 cycles, rdataM unchanged.
- lw with ack never asserted, TIMEOUT=4:
  - mem_req high 4 cycles then low
  - rdataM=0xDEADBEEF, bus_err pulses once, err_sticky stays 1.
- memwriteM=1 with ampM=0000:
  - stallM=0, mem_req stays 0.
- Stray mem_ack in IDLE:
  - no state change.
- Back-to-back sw then lw, ack same cycle each:
  - two separate mem_req pulses separated by a DONE and an IDLE cycle.
- reset asserted in second BUSY cycle:
  - next cycle state=IDLE, mem_req=0, stallM=0, rdataM=0.
